// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, default
// address width and byte-lane helpers.
package mem_pkg;

    // Word-address width used when the instantiating design does not override it
    localparam int ADDR_W_DEFAULT = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Pick one little-endian byte lane out of a 32-bit word (lane 0 = bits [7:0])
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, 2**ADDR_W words of 32 bits, with a
// registered read port and a whole-word write enable. Contents are not reset.
module dmem_ram #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rdata_q;

    // Write port and registered read share one address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder between the datapath memory stage and a data RAM.
// One request at a time: accept in IDLE, optionally READ and/or WRITE the
// RAM, then pulse a single-cycle response (with register write-back for loads).
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_rd,
    output logic        busy,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] w_data_ldr,
    output logic [3:0]  w_addr_ldr,
    output logic        w_en_ldr
);

    state_t state_q, state_d;

    logic              we_q;
    logic              byte_q;
    logic              err_q;
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic [3:0]        rd_q;

    logic        accept;
    logic        req_fault;
    logic [31:0] ram_rdata;
    logic [31:0] ram_wdata;
    logic        ram_re;
    logic        ram_we;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;

    // Out-of-range upper address bits, or a misaligned word access
    assign req_fault = (|req_addr[31:ADDR_W+2]) || (!req_byte && (|req_addr[1:0]));

    // Next-state selection for the request sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        state_d = ST_RESP;
                    end else if (!req_we || req_byte) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_READ:  state_d = (we_q && byte_q) ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request fields on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            lane_q  <= 2'd0;
            wdata_q <= 32'h0;
            rd_q    <= 4'h0;
        end else if (accept) begin
            we_q    <= req_we;
            byte_q  <= req_byte;
            err_q   <= req_fault;
            idx_q   <= req_addr[ADDR_W+1:2];
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
        end
    end

    // Write word: full store data, or the read word with one lane replaced
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign ram_wdata[8*gi +: 8] = !byte_q                ? wdata_q[8*gi +: 8] :
                                      (lane_q == 2'(gi))     ? wdata_q[7:0]       :
                                                               ram_rdata[8*gi +: 8];
    end

    // The write is withheld when reset coincides with the edge leaving WRITE
    assign ram_re = (state_q == ST_READ);
    assign ram_we = (state_q == ST_WRITE) && !rst;

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Response and load write-back; everything is zero outside RESP
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_err    = rsp_valid && err_q;
    assign w_en_ldr   = rsp_valid && !we_q && !err_q;
    assign w_addr_ldr = w_en_ldr ? rd_q : 4'h0;
    assign w_data_ldr = !w_en_ldr ? 32'h0 :
                        byte_q    ? {24'h0, lane_byte(ram_rdata, lane_q)} :
                                    ram_rdata;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning word-address width (memory depth 2**ADDR_W words of 32 bits).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  load/store request from the datapath memory stage.
REQ-005 SHALL have port req_ready  output  1  request accepted on an edge where req_valid and req_ready are both high.
REQ-006 SHALL have port req_we  input  1  1 = store (STR/STRB), 0 = load (LDR/LDRB).
REQ-007 SHALL have port req_byte  input  1  1 = byte access, 0 = word access.
REQ-008 SHALL have port req_addr  input  32  byte address (datapath address output).
REQ-009 SHALL have port req_wdata  input  32  store data (datapath store-data output); bits [7:0] used for byte stores.
REQ-010 SHALL have port req_rd  input  4  load destination register.
REQ-011 SHALL have port busy  output  1  high whenever not IDLE; pipeline stall.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_err  output  1  access fault, valid with rsp_valid.
REQ-014 SHALL have ports w_data_ldr  output  32, w_addr_ldr  output  4, w_en_ldr  output  1  register-file load write-back.

Function
REQ-015 SHALL use word index req_addr[ADDR_W+1:2]; byte lane req_addr[1:0], little-endian (lane 0 = bits [7:0]).
REQ-016 SHALL flag a fault when req_addr[31:ADDR_W+2] is nonzero, or when a word access has req_addr[1:0] != 0.
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = (state == IDLE); busy = !req_ready.
REQ-018 SHALL capture we, byte, addr, wdata and rd on acceptance; req_valid while busy is ignored; no queuing.
REQ-019 SHALL, on acceptance: fault -> RESP with no RAM access; load or byte store -> READ; word store -> WRITE.
REQ-020 SHALL in READ issue the RAM read; next state WRITE for a byte store, otherwise RESP.
REQ-021 SHALL in WRITE write the RAM on the edge leaving WRITE: full word for word stores; for byte stores the read word with only the addressed lane replaced by wdata[7:0] (read-modify-write); next state RESP.
REQ-022 SHALL in RESP hold rsp_valid high for exactly one cycle, then return to IDLE.
REQ-023 SHALL make latency from acceptance edge to rsp_valid cycle: fault 1, word store 2, load 2, byte store 3 cycles.
REQ-024 SHALL drive w_data_ldr with the read word (word load) or the addressed byte zero-extended (byte load).
REQ-025 SHALL assert w_en_ldr = rsp_valid & !we & !rsp_err, with w_addr_ldr = captured rd; w_data_ldr is 0 and w_en_ldr is 0 otherwise.
REQ-026 SHALL support back-to-back operation: a new request is accepted in the IDLE cycle immediately after RESP.
REQ-027 SHALL make a load of a word written by an immediately preceding store return the new value.

Reset
REQ-028 SHALL on rst enter IDLE and force rsp_valid=0, rsp_err=0, w_en_ldr=0, w_data_ldr=0, w_addr_ldr=0; req_ready=1 in the cycle after reset.
REQ-029 SHALL suppress the RAM write if rst is high on the edge leaving WRITE; an in-flight response is dropped.
REQ-030 SHALL not initialise RAM contents on reset.

Structure
REQ-031 SHALL take the FSM state enum and the default ADDR_W from the shared package mem_pkg.
REQ-032 SHALL instantiate one sub-module dmem_ram: single-port synchronous RAM, 2**ADDR_W x 32, 1-cycle registered read, whole-word write enable.

Verification
REQ-033 SHALL test: store word 0xDEADBEEF at 0x10, then load word 0x10, rd=3 -> rsp_valid 2 cycles after each acceptance; w_en_ldr=1, w_addr_ldr=3, w_data_ldr=0xDEADBEEF.
REQ-034 SHALL test: with word 0x11223344 at 0x20, store byte 0xAA at 0x22 -> rsp 3 cycles later; load word 0x20 returns 0x11AA3344; load byte 0x23 returns 0x00000011.
REQ-035 SHALL test: load word 0x21 -> rsp_valid and rsp_err 1 cycle later, w_en_ldr=0; load from 0x00010000 (ADDR_W=11) -> rsp_err=1, RAM unchanged.
REQ-036 SHALL test: req_valid held high continuously over 3 requests -> req_ready low while busy; each request accepted exactly once; no lost or duplicated responses.
REQ-037 SHALL test: rst pulsed while in WRITE of store 0x55 to 0x40 -> no rsp_valid, IDLE next cycle, word 0x40 keeps its previous value.
